window_motor_drv: RTL and testbench

WINDOW_MOTOR_DRV -- requirements
Module: window_motor_drv

---
 rtl/window_motor_drv.sv | 143 ++++++++++++++
 tb/tb_window_motor_drv.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/window_motor_drv.sv
// Power-window motor driver: dead-time sequenced open/close with limit and dual-limit fault handling.
// Optional motion timeout fault enabled by defining WINDOW_MOTOR_TIMEOUT_EN.
module window_motor_drv #(
    parameter int DEAD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic CLK,
    input  logic RST,
    input  logic OPEN_CW,
    input  logic CLOSE_CW,
    input  logic LIM_OPEN,
    input  logic LIM_CLOSED,
    output logic MOTOR_UP,
    output logic MOTOR_DN,
    output logic BUSY,
    output logic FAULT
);

    localparam int CMAX = (DEAD_CYCLES > TIMEOUT_CYCLES) ? DEAD_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(CMAX);
`ifdef WINDOW_MOTOR_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DEAD    = 3'd1,
        S_OPENING = 3'd2,
        S_CLOSING = 3'd3,
        S_FAULT   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            dir_up_q, dir_up_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            up_q, dn_q, busy_q, fault_q;
    logic            up_d, dn_d, busy_d, fault_d;

    logic open_req, close_req, dual_lim;
    assign open_req  = OPEN_CW & ~CLOSE_CW;
    assign close_req = CLOSE_CW & ~OPEN_CW;
    assign dual_lim  = LIM_OPEN & LIM_CLOSED;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            dir_up_q <= 1'b1;
            cnt_q    <= '0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_up_q <= dir_up_d;
            cnt_q    <= cnt_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        case (state_q)
            S_IDLE: begin
                if (open_req && !LIM_OPEN) begin
                    state_d  = S_DEAD;
                    dir_up_d = 1'b1;
                end else if (close_req && !LIM_CLOSED) begin
                    state_d  = S_DEAD;
                    dir_up_d = 1'b0;
                end
            end
            S_DEAD: begin
                if (cnt_q == DEAD_LAST)
                    state_d = dir_up_q ? S_OPENING : S_CLOSING;
            end
            S_OPENING: begin
                // Reversal wins over the limit reached in the same cycle.
                if (close_req && !LIM_CLOSED) begin
                    state_d  = S_DEAD;
                    dir_up_d = 1'b0;
                end else if (LIM_OPEN) begin
                    state_d = S_IDLE;
                end
`ifdef WINDOW_MOTOR_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d = S_FAULT;
                end
`endif
            end
            S_CLOSING: begin
                if (open_req && !LIM_OPEN) begin
                    state_d  = S_DEAD;
                    dir_up_d = 1'b1;
                end else if (LIM_CLOSED) begin
                    state_d = S_IDLE;
                end
`ifdef WINDOW_MOTOR_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d = S_FAULT;
                end
`endif
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_FAULT && dual_lim)
            state_d = S_FAULT;
        // Counter restarts on each state entry and saturates instead of wrapping.
        if (state_d != state_q)
            cnt_d = '0;
        else if (cnt_q == CNT_SAT)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CW'(1);
    end

    always_comb begin
        up_d    = 1'b0;
        dn_d    = 1'b0;
        busy_d  = 1'b0;
        fault_d = 1'b0;
        case (state_d)
            S_DEAD:    busy_d = 1'b1;
            S_OPENING: begin up_d = 1'b1; busy_d = 1'b1; end
            S_CLOSING: begin dn_d = 1'b1; busy_d = 1'b1; end
            S_FAULT:   fault_d = 1'b1;
            default:   ;
        endcase
    end

    assign MOTOR_UP = up_q;
    assign MOTOR_DN = dn_q;
    assign BUSY     = busy_q;
    assign FAULT    = fault_q;

endmodule

// File: tb/tb_window_motor_drv.sv
// Directed bench for window_motor_drv with DEAD_CYCLES=4, TIMEOUT_CYCLES=20.
// Outputs are compared as {MOTOR_UP, MOTOR_DN, BUSY, FAULT}.
module tb_window_motor_drv;

    logic CLK = 1'b0;
    logic RST, OPEN_CW, CLOSE_CW, LIM_OPEN, LIM_CLOSED;
    logic MOTOR_UP, MOTOR_DN, BUSY, FAULT;
    int   n_vec = 0;
    int   n_err = 0;

    window_motor_drv #(.DEAD_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
        .CLK(CLK), .RST(RST), .OPEN_CW(OPEN_CW), .CLOSE_CW(CLOSE_CW),
        .LIM_OPEN(LIM_OPEN), .LIM_CLOSED(LIM_CLOSED),
        .MOTOR_UP(MOTOR_UP), .MOTOR_DN(MOTOR_DN), .BUSY(BUSY), .FAULT(FAULT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] exp);
        chk(tag, {MOTOR_UP, MOTOR_DN, BUSY, FAULT}, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue a command pulse; returns in the first DEAD cycle.
    task automatic cmd(input logic op, input logic cl);
        OPEN_CW  = op;
        CLOSE_CW = cl;
        tick();
        OPEN_CW  = 1'b0;
        CLOSE_CW = 1'b0;
    endtask

    task automatic dead_then(input string tag, input logic [3:0] motion);
        for (int i = 0; i < 4; i++) begin
            chk_out({tag, "_dead"}, 4'b0010);
            tick();
        end
        chk_out({tag, "_move"}, motion);
    endtask

    initial begin
        RST = 1'b0; OPEN_CW = 1'b0; CLOSE_CW = 1'b0; LIM_OPEN = 1'b0; LIM_CLOSED = 1'b0;
        #3;
        chk_out("rst_async", 4'b0000);
        tick(); tick();
        chk_out("rst_held", 4'b0000);
        RST = 1'b1;

        // Open with dead time, stop at limit; first command right after release.
        cmd(1'b1, 1'b0);
        dead_then("open", 4'b1010);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("opening", 4'b1010);
        end
        LIM_OPEN = 1'b1;
        tick();
        chk_out("lim_open_stop", 4'b0000);
        cmd(1'b1, 1'b0);
        chk_out("open_at_lim", 4'b0000);
        LIM_OPEN = 1'b0;

        // Reversal while opening, accepted even with LIM_OPEN in the same cycle.
        cmd(1'b1, 1'b0);
        dead_then("open2", 4'b1010);
        tick();
        OPEN_CW = 1'b1;
        tick();
        OPEN_CW = 1'b0;
        chk_out("open_ignored", 4'b1010);
        LIM_OPEN = 1'b1;
        cmd(1'b0, 1'b1);
        LIM_OPEN = 1'b0;
        dead_then("rev", 4'b0110);
        cmd(1'b0, 1'b1);
        chk_out("close_ignored", 4'b0110);
        LIM_CLOSED = 1'b1;
        tick();
        chk_out("lim_closed_stop", 4'b0000);

        // Ignored commands in IDLE.
        cmd(1'b0, 1'b1);
        chk_out("close_at_lim", 4'b0000);
        tick();
        chk_out("close_at_lim2", 4'b0000);
        cmd(1'b1, 1'b1);
        chk_out("both_lim", 4'b0000);
        LIM_CLOSED = 1'b0;
        cmd(1'b1, 1'b1);
        chk_out("both_cmd", 4'b0000);
        tick();
        chk_out("both_cmd2", 4'b0000);

        // Dual limit while closing -> fault, sticky until reset.
        cmd(1'b0, 1'b1);
        dead_then("close", 4'b0110);
        LIM_OPEN = 1'b1; LIM_CLOSED = 1'b1;
        tick();
        chk_out("dual_fault", 4'b0001);
        LIM_OPEN = 1'b0; LIM_CLOSED = 1'b0;
        cmd(1'b1, 1'b0);
        chk_out("fault_sticky", 4'b0001);
        tick();
        chk_out("fault_sticky2", 4'b0001);
        #2 RST = 1'b0;
        #1 chk_out("fault_rst", 4'b0000);
        #1 RST = 1'b1;

        // Async reset mid-opening, then full restart.
        cmd(1'b1, 1'b0);
        dead_then("open3", 4'b1010);
        #2 RST = 1'b0;
        #1 chk_out("rst_mid_motion", 4'b0000);
        #1 RST = 1'b1;
        cmd(1'b1, 1'b0);
        dead_then("restart", 4'b1010);

        // Timeout behaviour.
        #2 RST = 1'b0;
        #2 RST = 1'b1;
        cmd(1'b1, 1'b0);
        dead_then("to", 4'b1010);
`ifdef WINDOW_MOTOR_TIMEOUT_EN
        for (int i = 1; i < 20; i++) begin
            tick();
            chk_out("to_moving", 4'b1010);
        end
        tick();
        chk_out("to_fault", 4'b0001);
        cmd(1'b0, 1'b1);
        chk_out("to_fault_sticky", 4'b0001);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            chk_out("no_timeout", 4'b1010);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Continuous overlap guard; counted only when a violation occurs.
    always @(negedge CLK) begin
        if (RST && MOTOR_UP && MOTOR_DN)
            chk("overlap", {MOTOR_UP, MOTOR_DN, 2'b00}, 4'b0000);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
